stopwatch_ctrl: RTL and testbench

//  Run/pause/clear controller for the 1 Hz LED seconds counter.

---
 rtl/stopwatch_ctrl_if.sv | 22 ++
 rtl/stopwatch_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Pushbutton inputs and LED/status outputs of the stopwatch controller.
interface stopwatch_ctrl_if #(
    parameter int unsigned CNT_W = 4
);
    logic             btn_start_n;
    logic             btn_clear_n;
    logic             btn_lap_n;
    logic [CNT_W-1:0] led;
    logic             running;
    logic             tick;
    logic             wrap;

    modport master (
        output btn_start_n, btn_clear_n, btn_lap_n,
        input  led, running, tick, wrap
    );

    modport slave (
        input  btn_start_n, btn_clear_n, btn_lap_n,
        output led, running, tick, wrap
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller driving the LED seconds count from debounced pushbuttons.
// Define LAP_HOLD_EN to enable the lap button, which freezes led on a count snapshot.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV     = 12000000,
    parameter int unsigned DEBOUNCE_CYC = 120000,
    parameter int unsigned CNT_W        = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    stopwatch_ctrl_if.slave bus
);

`ifdef LAP_HOLD_EN
    localparam int unsigned NBTN = 3;
`else
    localparam int unsigned NBTN = 2;
`endif
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned PS_W  = $clog2(TICK_DIV);
    localparam int unsigned B_STA = 0;
    localparam int unsigned B_CLR = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    logic [NBTN-1:0] raw_n;
    logic [NBTN-1:0] sync1_q, sync1_d;
    logic [NBTN-1:0] sync2_q, sync2_d;
    logic [NBTN-1:0] deb_q,   deb_d;
    logic [NBTN-1:0] press_q, press_d;
    logic [DB_W-1:0] cnt_q [NBTN];
    logic [DB_W-1:0] cnt_d [NBTN];

    state_e           state_q, state_d;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] led_q,   led_d;
    logic             running_q, running_d;
    logic             tick_q,    tick_d;
    logic             wrap_q,    wrap_d;

    logic start_ev;
    logic clear_ev;
    logic adv;

`ifdef LAP_HOLD_EN
    localparam int unsigned B_LAP = 2;
    logic             lap_ev;
    logic             hold_q, hold_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    assign raw_n = {bus.btn_lap_n, bus.btn_clear_n, bus.btn_start_n};
`else
    logic unused_lap;
    assign unused_lap = bus.btn_lap_n;
    assign raw_n      = {bus.btn_clear_n, bus.btn_start_n};
`endif

    // Synchronise, then accept a level only after it has held for DEBOUNCE_CYC cycles.
    always_comb begin
        sync1_d = raw_n;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        press_d = '0;
        for (int i = 0; i < int'(NBTN); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    deb_d[i]   = sync2_q[i];
                    press_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign start_ev = press_q[B_STA];
    assign clear_ev = press_q[B_CLR];
`ifdef LAP_HOLD_EN
    assign lap_ev   = press_q[B_LAP];
`endif

    // Mode FSM, prescaler and count; clear overrides every other event.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        count_d   = count_q;
        tick_d    = 1'b0;
        wrap_d    = 1'b0;
        adv       = 1'b0;

        case (state_q)
            IDLE:    if (start_ev) state_d = RUN;
            RUN:     if (start_ev) state_d = PAUSE;
            PAUSE:   if (start_ev) state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (clear_ev) begin
            state_d = IDLE;
            presc_d = '0;
            count_d = '0;
        end else begin
            // Only cycles that stay in RUN advance the period.
            adv = (state_q == RUN) && (state_d == RUN);
            if (adv) begin
                if (presc_q == PS_W'(TICK_DIV - 1)) begin
                    presc_d = '0;
                    count_d = count_q + CNT_W'(1);
                    tick_d  = 1'b1;
                    wrap_d  = &count_q;
                end else begin
                    presc_d = presc_q + PS_W'(1);
                end
            end
        end

        running_d = (state_d == RUN);

`ifdef LAP_HOLD_EN
        hold_d = hold_q;
        snap_d = snap_q;
        if (clear_ev) begin
            hold_d = 1'b0;
        end else if (lap_ev && (state_q != IDLE)) begin
            if (hold_q) begin
                hold_d = 1'b0;
            end else begin
                hold_d = 1'b1;
                snap_d = count_q;
            end
        end
        led_d = hold_d ? snap_d : count_d;
`else
        led_d = count_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            deb_q     <= '1;
            press_q   <= '0;
            for (int i = 0; i < int'(NBTN); i++) cnt_q[i] <= '0;
            state_q   <= IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            led_q     <= '0;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
`ifdef LAP_HOLD_EN
            hold_q    <= 1'b0;
            snap_q    <= '0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            press_q   <= press_d;
            for (int i = 0; i < int'(NBTN); i++) cnt_q[i] <= cnt_d[i];
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            led_q     <= led_d;
            running_q <= running_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
`ifdef LAP_HOLD_EN
            hold_q    <= hold_d;
            snap_q    <= snap_d;
`endif
        end
    end

    assign bus.led     = led_q;
    assign bus.running = running_q;
    assign bus.tick    = tick_q;
    assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios then random button activity.
module tb_stopwatch_ctrl;

    localparam int TD  = 5;
    localparam int DB  = 4;
    localparam int NE  = 16384;
    localparam int LAT = 2 + DB + 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    stopwatch_ctrl_if #(.CNT_W(4)) bus ();

    stopwatch_ctrl #(
        .TICK_DIV    (TD),
        .DEBOUNCE_CYC(DB),
        .CNT_W       (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Scheduled button effects, indexed by the clock edge on which they land.
    bit ev_s [NE];
    bit ev_c [NE];
    bit ev_l [NE];

    int n      = 0;
    int m_st   = M_IDLE;
    int m_runc = 0;
    int m_hold = 0;
    int m_snap = 0;
    int e_led  = 0;
    int e_run  = 0;
    int e_tick = 0;
    int e_wrap = 0;

    // Reference model: elapsed RUN cycles determine the count by division.
    always @(posedge clk or negedge rst_n) begin
        int cnt_before;
        if (!rst_n) begin
            m_st = M_IDLE; m_runc = 0; m_hold = 0; m_snap = 0;
            e_led = 0; e_run = 0; e_tick = 0; e_wrap = 0;
        end else begin
            n = n + 1;
            cnt_before = (m_runc / TD) % 16;
            e_tick = 0;
            e_wrap = 0;
            if (n < NE && ev_c[n]) begin
                m_st = M_IDLE; m_runc = 0; m_hold = 0;
            end else begin
                if (m_st == M_RUN && !(n < NE && ev_s[n])) begin
                    m_runc = (m_runc + 1) % (TD * 16);
                    if (m_runc % TD == 0) begin
                        e_tick = 1;
                        e_wrap = (m_runc == 0) ? 1 : 0;
                    end
                end
`ifdef LAP_HOLD_EN
                if (n < NE && ev_l[n] && m_st != M_IDLE) begin
                    if (m_hold != 0) m_hold = 0;
                    else begin m_hold = 1; m_snap = cnt_before; end
                end
`endif
                if (n < NE && ev_s[n]) m_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
            end
            e_led = (m_hold != 0) ? m_snap : (m_runc / TD) % 16;
            e_run = (m_st == M_RUN) ? 1 : 0;
        end
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, exp, n);
        end
    endtask

    task automatic check_all();
        cmp("led",     32'(bus.led),     32'(e_led));
        cmp("running", 32'(bus.running), 32'(e_run));
        cmp("tick",    32'(bus.tick),    32'(e_tick));
        cmp("wrap",    32'(bus.wrap),    32'(e_wrap));
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic press(input bit s, input bit c, input bit l, input int hold, input int gap);
        @(posedge clk); #1;
        if (n + LAT < NE) begin
            if (s) ev_s[n + LAT] = 1'b1;
            if (c) ev_c[n + LAT] = 1'b1;
            if (l) ev_l[n + LAT] = 1'b1;
        end
        if (s) bus.btn_start_n = 1'b0;
        if (c) bus.btn_clear_n = 1'b0;
        if (l) bus.btn_lap_n   = 1'b0;
        step(hold);
        @(posedge clk); #1;
        bus.btn_start_n = 1'b1;
        bus.btn_clear_n = 1'b1;
        bus.btn_lap_n   = 1'b1;
        step(gap);
    endtask

    task automatic glitch(input bit s, input bit c, input int len);
        @(posedge clk); #1;
        if (s) bus.btn_start_n = 1'b0;
        if (c) bus.btn_clear_n = 1'b0;
        step(len - 1);
        @(posedge clk); #1;
        bus.btn_start_n = 1'b1;
        bus.btn_clear_n = 1'b1;
        step(6);
    endtask

    task automatic mid_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        cmp("rst_led",     32'(bus.led),     32'(0));
        cmp("rst_running", 32'(bus.running), 32'(0));
        cmp("rst_tick",    32'(bus.tick),    32'(0));
        cmp("rst_wrap",    32'(bus.wrap),    32'(0));
        step(3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(5);
    endtask

    initial begin
        bus.btn_start_n = 1'b1;
        bus.btn_clear_n = 1'b1;
        bus.btn_lap_n   = 1'b1;
        step(3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(3);

        // Start, then let the count run and roll over.
        press(1'b1, 1'b0, 1'b0, 10, 12);
        glitch(1'b1, 1'b0, 3);
        glitch(1'b0, 1'b1, 3);
        step(16 * TD + 10);

        // Pause mid-period, sit idle, resume.
        press(1'b1, 1'b0, 1'b0, 10, 20);
        press(1'b1, 1'b0, 1'b0, 10, 15);

        // Lap toggling while running.
        press(1'b0, 1'b0, 1'b1, 9, 12);
        press(1'b0, 1'b0, 1'b1, 9, 12);

        // Simultaneous clear and start while running.
        press(1'b1, 1'b1, 1'b0, 10, 12);
        step(8);

        // Asynchronous reset while running.
        press(1'b1, 1'b0, 1'b0, 10, 20);
        mid_reset();

        for (int it = 0; it < 60; it++) begin
            int act;
            act = int'($urandom_range(0, 6));
            case (act)
                0, 1: press(1'b1, 1'b0, 1'b0, int'($urandom_range(8, 12)), int'($urandom_range(10, 14)));
                2:    press(1'b0, 1'b1, 1'b0, int'($urandom_range(8, 12)), int'($urandom_range(10, 14)));
                3:    glitch($urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, int'($urandom_range(1, 3)));
                4:    press(1'b0, 1'b0, 1'b1, int'($urandom_range(8, 12)), int'($urandom_range(10, 14)));
                5:    press(1'b1, 1'b1, $urandom_range(0, 1) == 0, 10, 12);
                default: step(int'($urandom_range(5, 60)));
            endcase
        end
        mid_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
